// File: rtl/rmw_pkg.sv
// Shared types and constants for the 6502 read-modify-write sequencer.
// RMW_DUMMY_WRITE_EN adds the DUMMY state (NMOS double write).
package rmw_pkg;

    // Instruction encoding on the op port (6/7 are illegal and never stored)
    typedef enum logic [2:0] {
        RMW_ASL = 3'd0,
        RMW_LSR = 3'd1,
        RMW_ROL = 3'd2,
        RMW_ROR = 3'd3,
        RMW_INC = 3'd4,
        RMW_DEC = 3'd5
    } rmw_op_e;

    // External ALU opcodes
    localparam logic [3:0] ALU_PASS = 4'h0;
    localparam logic [3:0] ALU_ASL  = 4'h3;
    localparam logic [3:0] ALU_DEC  = 4'h6;
    localparam logic [3:0] ALU_INC  = 4'h7;
    localparam logic [3:0] ALU_LSR  = 4'hA;
    localparam logic [3:0] ALU_ROL  = 4'hC;
    localparam logic [3:0] ALU_ROR  = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
`ifdef RMW_DUMMY_WRITE_EN
        S_DUMMY,
`endif
        S_WRITE,
        S_DONE
    } state_e;

    // Map an RMW instruction onto the ALU opcode used during EXEC
    function automatic logic [3:0] alu_code(input rmw_op_e o);
        case (o)
            RMW_ASL: return ALU_ASL;
            RMW_LSR: return ALU_LSR;
            RMW_ROL: return ALU_ROL;
            RMW_ROR: return ALU_ROR;
            RMW_INC: return ALU_INC;
            RMW_DEC: return ALU_DEC;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/rmw_seq.sv
// rmw_seq: read / ALU pass / write-back sequencer for 6502 RMW instructions.
// Build option: define RMW_DUMMY_WRITE_EN for the NMOS dummy write of the
// unmodified operand ahead of the result; otherwise the result is written once.
module rmw_seq
    import rmw_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] addr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic [7:0]    alu_a,
    output logic [3:0]    alu_op,
    input  logic [7:0]    alu_y,
    input  logic [7:0]    alu_flags,
    output logic          p_we,
    output logic [7:0]    p_o
);

    state_e        state, state_nx;
    logic [AW-1:0] addr_q;
    rmw_op_e       op_q;
    logic          err_q;
    logic [7:0]    opnd;
    logic [7:0]    res;
    logic [7:0]    p_q;
    logic          p_we_q;

    wire op_legal = (op <= 3'd5);

    // State register; reset abandons any bus cycle in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state and all bus/ALU/status outputs, decoded from the state
    always_comb begin
        state_nx  = state;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        alu_a     = 8'h00;
        alu_op    = ALU_PASS;
        case (state)
            S_IDLE: begin
                if (start) state_nx = op_legal ? S_READ : S_DONE;
            end
            S_READ: begin
                mem_req = 1'b1;
                if (mem_ack) state_nx = S_EXEC;
            end
            S_EXEC: begin
                alu_a  = opnd;
                alu_op = alu_code(op_q);
`ifdef RMW_DUMMY_WRITE_EN
                state_nx = S_DUMMY;
`else
                state_nx = S_WRITE;
`endif
            end
`ifdef RMW_DUMMY_WRITE_EN
            S_DUMMY: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = opnd;
                if (mem_ack) state_nx = S_WRITE;
            end
`endif
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = res;
                if (mem_ack) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                err      = err_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: request capture, operand, ALU result and flags for P
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            op_q   <= RMW_ASL;
            err_q  <= 1'b0;
            opnd   <= 8'h00;
            res    <= 8'h00;
            p_q    <= 8'h00;
            p_we_q <= 1'b0;
        end else begin
            p_we_q <= (state == S_EXEC);
            if (state == S_IDLE && start) begin
                addr_q <= addr;
                err_q  <= !op_legal;
                op_q   <= op_legal ? rmw_op_e'(op) : RMW_ASL;
            end
            if (state == S_READ && mem_ack) opnd <= mem_rdata;
            if (state == S_EXEC) begin
                res <= alu_y;
                p_q <= alu_flags;
            end
        end
    end

    assign mem_addr = addr_q;
    assign p_we     = p_we_q;
    assign p_o      = p_q;

endmodule
